// File: rtl/had_jtag2_ctrl_if.sv
// -----------------------------------------------------------------------------
// had_jtag2_ctrl_if
// Parallel register-access bus between the two-wire HAD protocol engine and
// the HAD register bank.
//   ir      : captured register address (engine -> bank)
//   wr_vld  : one-cycle write strobe (engine -> bank)
//   wr_data : write data, valid with wr_vld and held afterwards (engine -> bank)
//   rd_req  : one-cycle read request (engine -> bank)
//   rd_data : read data (bank -> engine)
// master = protocol engine, slave = register bank.
// -----------------------------------------------------------------------------
interface had_jtag2_ctrl_if #(
  parameter int IR_W   = 8,
  parameter int DATA_W = 32
);
  logic [IR_W-1:0]   ir;
  logic              wr_vld;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;

  modport master (output ir, wr_vld, wr_data, rd_req, input rd_data);
  modport slave  (input ir, wr_vld, wr_data, rd_req, output rd_data);
endinterface

// File: rtl/had_jtag2_ctrl.sv
// -----------------------------------------------------------------------------
// had_jtag2_ctrl
// Two-wire (TMS/TCLK) serial protocol engine for the HAD debug port. Decodes
// host frames (start, RW, IR, IR parity, turnaround, data, data parity) into
// register accesses on the bus interface and drives the TMS return path.
// Ports:
//   tclk, trst_b : clock (posedge) and asynchronous active-low reset
//   tap_on       : port enable; low forces IDLE and aborts any frame
//   tms_i        : TMS from pad stage
//   tms_o/tms_oe : registered TMS drive value / enable to pad stage
//   bus          : register-bank access interface (master side)
//   par_err      : sticky parity-error flag, err_clr clears it (set wins)
// -----------------------------------------------------------------------------
module had_jtag2_ctrl #(
  parameter int IR_W   = 8,
  parameter int DATA_W = 32
) (
  input  logic              tclk,
  input  logic              trst_b,
  input  logic              tap_on,
  input  logic              tms_i,
  output logic              tms_o,
  output logic              tms_oe,
  had_jtag2_ctrl_if.master  bus,
  output logic              par_err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] IR_LAST   = CNT_W'(IR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RW, S_IR, S_IR_PAR, S_TRN1,
    S_WR_DATA, S_WR_PAR, S_TRN2, S_SYNC, S_TRN3,
    S_RD_DATA, S_RD_PAR, S_TRN4
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              par_acc, par_acc_nxt;   // xor of bits received in current parity group
  logic              rw, rw_nxt;
  logic              ir_bad, ir_bad_nxt;
  logic              wr_ok, wr_ok_nxt;       // last write accepted, reported in SYNC
  logic              rd_par, rd_par_nxt;     // odd-parity bit for the word being read out
  logic [IR_W-1:0]   ir_q, ir_nxt;
  logic [DATA_W-1:0] wr_data_q, wr_data_nxt;
  logic              wr_vld_q, wr_vld_nxt;
  logic              rd_req_q, rd_req_nxt;
  logic              tms_o_nxt, tms_oe_nxt;
  logic              set_err;
  logic [DATA_W-1:0] rd_load;

  assign bus.ir      = ir_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_vld  = wr_vld_q;
  assign bus.rd_req  = rd_req_q;

  // A bad IR address returns zeros instead of bank data.
  assign rd_load = ir_bad ? '0 : bus.rd_data;

  // Outputs are computed for the state being entered, so they are registered
  // and valid for the whole cycle of that state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    par_acc_nxt = par_acc;
    rw_nxt      = rw;
    ir_bad_nxt  = ir_bad;
    wr_ok_nxt   = wr_ok;
    rd_par_nxt  = rd_par;
    ir_nxt      = ir_q;
    wr_data_nxt = wr_data_q;
    wr_vld_nxt  = 1'b0;
    rd_req_nxt  = 1'b0;
    tms_o_nxt   = 1'b0;
    tms_oe_nxt  = 1'b0;
    set_err     = 1'b0;

    unique case (state)
      S_IDLE: if (!tms_i) state_nxt = S_RW;
      S_RW: begin
        rw_nxt      = tms_i;
        par_acc_nxt = tms_i;
        cnt_nxt     = '0;
        state_nxt   = S_IR;
      end
      S_IR: begin
        // LSB first: shift in at the top; the IR ends up in the upper IR_W bits.
        shreg_nxt   = {tms_i, shreg[DATA_W-1:1]};
        par_acc_nxt = par_acc ^ tms_i;
        cnt_nxt     = cnt + CNT_W'(1);
        if (cnt == IR_LAST) state_nxt = S_IR_PAR;
      end
      S_IR_PAR: begin
        ir_nxt     = shreg[DATA_W-1 -: IR_W];
        ir_bad_nxt = ~(par_acc ^ tms_i);
        set_err    = ~(par_acc ^ tms_i);
        rd_req_nxt = rw;
        state_nxt  = S_TRN1;
      end
      S_TRN1: begin
        cnt_nxt = '0;
        if (rw) begin
          shreg_nxt  = rd_load;
          rd_par_nxt = ~^rd_load;
          tms_oe_nxt = 1'b1;
          tms_o_nxt  = rd_load[0];
          state_nxt  = S_RD_DATA;
        end else begin
          par_acc_nxt = 1'b0;
          state_nxt   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        shreg_nxt   = {tms_i, shreg[DATA_W-1:1]};
        par_acc_nxt = par_acc ^ tms_i;
        cnt_nxt     = cnt + CNT_W'(1);
        if (cnt == DATA_LAST) state_nxt = S_WR_PAR;
      end
      S_WR_PAR: begin
        set_err   = ~(par_acc ^ tms_i);
        wr_ok_nxt = ~ir_bad & (par_acc ^ tms_i);
        if (~ir_bad & (par_acc ^ tms_i)) begin
          wr_vld_nxt  = 1'b1;
          wr_data_nxt = shreg;
        end
        state_nxt = S_TRN2;
      end
      S_TRN2: begin
        tms_oe_nxt = 1'b1;
        tms_o_nxt  = wr_ok;
        state_nxt  = S_SYNC;
      end
      S_SYNC:  state_nxt = S_TRN3;
      S_TRN3:  state_nxt = S_IDLE;
      S_RD_DATA: begin
        shreg_nxt  = shreg >> 1;
        cnt_nxt    = cnt + CNT_W'(1);
        tms_oe_nxt = 1'b1;
        if (cnt == DATA_LAST) begin
          tms_o_nxt = rd_par;
          state_nxt = S_RD_PAR;
        end else begin
          tms_o_nxt = shreg[1];
        end
      end
      S_RD_PAR: state_nxt = S_TRN4;
      S_TRN4:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Port disabled: abort the frame silently, keep ir and par_err.
    if (!tap_on) begin
      state_nxt   = S_IDLE;
      tms_oe_nxt  = 1'b0;
      tms_o_nxt   = 1'b0;
      wr_vld_nxt  = 1'b0;
      rd_req_nxt  = 1'b0;
      set_err     = 1'b0;
      ir_nxt      = ir_q;
      wr_data_nxt = wr_data_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par_acc   <= 1'b0;
      rw        <= 1'b0;
      ir_bad    <= 1'b0;
      wr_ok     <= 1'b0;
      rd_par    <= 1'b0;
      ir_q      <= '0;
      wr_data_q <= '0;
      wr_vld_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      tms_o     <= 1'b0;
      tms_oe    <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      par_acc   <= par_acc_nxt;
      rw        <= rw_nxt;
      ir_bad    <= ir_bad_nxt;
      wr_ok     <= wr_ok_nxt;
      rd_par    <= rd_par_nxt;
      ir_q      <= ir_nxt;
      wr_data_q <= wr_data_nxt;
      wr_vld_q  <= wr_vld_nxt;
      rd_req_q  <= rd_req_nxt;
      tms_o     <= tms_o_nxt;
      tms_oe    <= tms_oe_nxt;
      // A parity error on the same edge as err_clr wins.
      par_err   <= set_err | (par_err & ~err_clr);
    end
  end

endmodule

// File: doc/had_jtag2_ctrl.md
Name: had_jtag2_ctrl

Overview:
Two-wire (TMS/TCLK) serial protocol engine for the HAD debug port. It sits directly downstream of the pad/JDB interface stage. It consumes the raw TMS input from that stage and drives back the TMS output value and output-enable. It decodes host transactions into a parallel register-access interface (IR address, write strobe/data, read request/data) towards the HAD register bank.

Parameters:
IR_W, 8, width of the register address field (IR)
DATA_W, 32, width of the data field

Ports:
tclk  input  1  JTAG clock; all state on posedge
trst_b  input  1  asynchronous active-low reset
tap_on  input  1  port enable from pad stage; 0 forces IDLE synchronously
tms_i  input  1  TMS value from pad stage
tms_o  output  1  TMS drive value to pad stage (registered)
tms_oe  output  1  TMS output enable to pad stage (registered, 1 = drive)
ir  output  IR_W  captured register address; stable from IR_PAR exit until next IR capture
wr_vld  output  1  one-cycle write strobe
wr_data  output  DATA_W  write data, valid while wr_vld=1 and held afterwards
rd_req  output  1  one-cycle read request
rd_data  input  DATA_W  read data from register bank, sampled on the edge ending TRN1
par_err  output  1  sticky parity-error flag
err_clr  input  1  synchronous clear of par_err

Behaviour:
- Reset (trst_b=0): state IDLE; tms_o=0, tms_oe=0, ir=0, wr_vld=0, wr_data=0, rd_req=0, par_err=0, shift register and counter 0.
- Frame, host to block, one bit per tclk, all fields LSB first:
  - start bit, tms_i=0
  - RW bit: 1 = read, 0 = write
  - IR_W IR bits
  - IR parity bit
- Odd parity everywhere: the parity bit makes the total count of ones (covered bits plus parity) odd. IR parity covers RW+IR; data parity covers the DATA_W data bits.
- States and transitions, one cycle each unless counted:
  - IDLE: tms_i=0 sampled -> RW; otherwise stay.
  - RW: latch the RW bit; go to IR.
  - IR: IR_W cycles; shift in the bits; go to IR_PAR.
  - IR_PAR: check parity; load ir; on mismatch set ir_bad and par_err; go to TRN1.
  - TRN1: tms_oe=0; rd_req=1 if read.
    - Read: go to RD_DATA, loading the shift register with rd_data, or with 0 if ir_bad.
    - Write: go to WR_DATA.
  - WR_DATA: DATA_W cycles; shift in tms_i; go to WR_PAR.
  - WR_PAR: check data parity.
    - wr_vld=1 for exactly the next cycle only if IR and data parity are both good; wr_data is updated on the same edge.
    - On data parity mismatch, set par_err.
    - Go to TRN2.
  - TRN2 (write): tms_oe=0; go to SYNC.
  - SYNC: tms_oe=1; tms_o=1 if the write was accepted, 0 otherwise; go to TRN3.
  - TRN3: tms_oe=0; go to IDLE.
  - RD_DATA: DATA_W cycles; tms_oe=1; tms_o = current LSB; shift right each cycle; go to RD_PAR.
  - RD_PAR: tms_oe=1; tms_o = odd parity of the data shifted out; go to TRN4.
  - TRN4: tms_oe=0; go to IDLE.
- Output timing: tms_o/tms_oe are registered from next-state logic. They are valid for the whole cycle of the state they belong to, and the host samples them on the edge ending that state.
- Bit counter: log2(DATA_W) bits, reused for the IR and data phases, cleared on phase entry. It wraps only via the state exit; no overflow path.
- tap_on=0 in any state: next state is IDLE, tms_oe=0, wr_vld/rd_req=0. This aborts a write with no strobe. ir and par_err are retained.
- err_clr versus a simultaneous parity error: set wins.
- Back-to-back frames: a start bit is accepted in the first IDLE cycle after TRN3/TRN4.
- Reset mid-frame: immediate return to the reset values, with no strobe.

Test Plan:
- Write: start, RW=0, IR=0x12, IRpar=1, TRN, data 0xA5A50001, Dpar=0 -> wr_vld one cycle, ir=0x12, wr_data=0xA5A50001, SYNC drives tms_o=1 with tms_oe=1, par_err=0.
- Read: RW=1, IR=0x03, IRpar=0, rd_data=0x80000000 -> rd_req pulse in TRN1; tms_o drives 31×0, then 1, then parity 0, with tms_oe=1 over 33 cycles; TRN4 has tms_oe=0.
- IR parity error on write (IR=0x12, IRpar=0) -> no wr_vld, SYNC tms_o=0, par_err=1; err_clr then clears it to 0.
- Data parity error (0xA5A50001, Dpar=1) -> no wr_vld, SYNC tms_o=0, par_err=1.
- IR parity error on read -> 32 zero bits, then parity bit 1.
- tap_on dropped at data bit 10 of a write -> IDLE next cycle, no wr_vld, tms_oe=0. A following full write succeeds.
- Back-to-back write then read with no idle gap beyond one IDLE cycle -> both complete; trst_b pulse mid-read returns all outputs to reset values.
